// File: rtl/pd_pkg.sv
// Shared types and constants for the pattern-detector memory interface.
package pd_pkg;

    typedef enum logic [1:0] {
        PW_IDLE  = 2'd0,
        PW_WRITE = 2'd1,
        PW_LEN   = 2'd2,
        PW_DONE  = 2'd3
    } pw_state_t;

    localparam int          PD_ADDR_W   = 10;
    localparam int          PD_DATA_W   = 10;
    localparam logic [9:0]  PD_LEN_ADDR = 10'd1023;
    localparam int          PD_PAT_LEN  = 8;
    localparam logic [7:0]  PD_PATTERN  = 8'b11001010;

endpackage

// File: rtl/pd_dff.sv
// Parameterised register with asynchronous active-low reset to a chosen value.
module pd_dff #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= RST_VAL;
        else        q <= d;
    end

endmodule

// File: rtl/pd_match_counter.sv
// Counts (overlapping) occurrences of PATTERN in the accepted bit stream, saturating.
import pd_pkg::*;

module pd_match_counter #(
    parameter int                 ADDR_W  = PD_ADDR_W,
    parameter int                 PAT_LEN = PD_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = PD_PATTERN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              shift_en,
    input  logic              bit_in,
    output logic [ADDR_W-1:0] cnt
);

    logic [PAT_LEN-1:0] sr;
    logic [PAT_LEN-1:0] sr_next;

    // Oldest bit ends up in the MSB, matching PATTERN's ordering.
    assign sr_next = {sr[PAT_LEN-2:0], bit_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= '0;
            cnt <= '0;
        end else if (clear) begin
            sr  <= '0;
            cnt <= '0;
        end else if (shift_en) begin
            sr <= sr_next;
            if (sr_next == PATTERN && cnt != '1)
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pd_stream_writer.sv
// Writes a serial bit stream into memory words 0.., then the length word at the top address.
// Optional expected-match counter enabled by defining PW_EXPCNT_EN.
import pd_pkg::*;

module pd_stream_writer #(
    parameter int DATA_W = PD_DATA_W,
    parameter int ADDR_W = PD_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic              bit_last,
    output logic              bit_ready,
    output logic              wen,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              done,
    output logic [ADDR_W-1:0] exp_cnt
);

    localparam logic [ADDR_W-1:0] LEN_ADDR  = '1;
    localparam logic [ADDR_W-1:0] LAST_DATA = LEN_ADDR - 1'b1;

    logic [1:0]        state_raw;
    pw_state_t         state_q;
    pw_state_t         state_d;
    logic [ADDR_W-1:0] wptr_q;
    logic [ADDR_W-1:0] wptr_d;
    logic [ADDR_W-1:0] len_q;
    logic              xfer;
    logic              end_stream;

    assign state_q   = pw_state_t'(state_raw);
    assign bit_ready = (state_q == PW_WRITE);
    assign xfer      = bit_valid && bit_ready;

    pd_dff #(.W(2), .RST_VAL(PW_IDLE)) u_state (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (state_d),
        .q     (state_raw)
    );

    pd_dff #(.W(ADDR_W), .RST_VAL('0)) u_wptr (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (wptr_d),
        .q     (wptr_q)
    );

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        end_stream = 1'b0;
        case (state_q)
            PW_IDLE, PW_DONE: begin
                if (start) begin
                    state_d = PW_WRITE;
                    wptr_d  = '0;
                end
            end
            PW_WRITE: begin
                if (xfer) begin
                    wptr_d = wptr_q + 1'b1;
                    // Word LAST_DATA is the final data slot; the one above holds the length.
                    if (bit_last || wptr_q == LAST_DATA) begin
                        state_d    = PW_LEN;
                        end_stream = 1'b1;
                    end
                end
            end
            PW_LEN:  state_d = PW_DONE;
            default: state_d = PW_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen   <= 1'b0;
            addr  <= '0;
            wdata <= '0;
            done  <= 1'b0;
            len_q <= '0;
        end else begin
            wen  <= 1'b0;
            done <= (state_q == PW_DONE) && !start;
            if (xfer) begin
                wen   <= 1'b1;
                addr  <= wptr_q;
                wdata <= {{(DATA_W-1){1'b0}}, bit_in};
            end else if (state_q == PW_LEN) begin
                wen   <= 1'b1;
                addr  <= LEN_ADDR;
                wdata <= DATA_W'(len_q);
            end
            if (end_stream)
                len_q <= wptr_q;
        end
    end

`ifdef PW_EXPCNT_EN
    logic restart;
    assign restart = start && (state_q == PW_IDLE || state_q == PW_DONE);

    pd_match_counter #(.ADDR_W(ADDR_W)) u_match (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (restart),
        .shift_en (xfer),
        .bit_in   (bit_in),
        .cnt      (exp_cnt)
    );
`else
    assign exp_cnt = '0;
`endif

endmodule

// File: doc/pd_stream_writer.md
Name: pd_stream_writer

Overview:
- Writer side of the pattern-detector memory interface: it builds the memory image that the pattern detector later scans.
- Serial bits arrive over a valid/ready handshake. Each accepted bit is written to data[0] of consecutive words starting at address 0.
- When the stream ends, the length word is written to the top address (1023), then done is raised.
- The block also tracks, in hardware, how many pattern occurrences the detector should later flag, for self-checking test benches.

Parameters:
- DATA_W, 10, memory word width; the stream bit goes in bit 0, upper bits are zero.
- ADDR_W, 10, address width; the top address 2^ADDR_W-1 is reserved for the length word.
- PAT_LEN, 8, pattern length in bits.
- PATTERN, 8'b11001010, target sequence; MSB is the oldest bit.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a new image (honoured in IDLE and DONE only).
- bit_valid  in  1  bit_in/bit_last are valid this cycle.
- bit_in  in  1  serial stream bit.
- bit_last  in  1  marks the final bit of the stream.
- bit_ready  out  1  block accepts a bit this cycle.
- wen  out  1  memory write enable (registered).
- addr  out  ADDR_W  memory write address (registered).
- wdata  out  DATA_W  memory write data (registered).
- done  out  1  image complete.
- exp_cnt  out  ADDR_W  expected detector flag count (only with PW_EXPCNT_EN).

Behaviour:
- Clock and reset: single clock. Reset is asynchronous, active-low, on rst_n.
- Reset values: state=IDLE, wptr=0, wen=0, addr=0, wdata=0, done=0, shift register=0, exp_cnt=0.
- bit_ready is combinational and equals (state==WRITE). A transfer happens on a clock edge when bit_valid && bit_ready.
- IDLE: wen=0. On start, go to WRITE and clear wptr, the shift register and exp_cnt.
- WRITE, on a transfer:
  - next cycle: wen=1, addr=wptr, wdata={0, bit_in}.
  - wptr increments.
  - if bit_last=1 or wptr==2^ADDR_W-2 (index 1022, the last data word), latch len=wptr and go to LEN.
- WRITE, no transfer: wen=0 next cycle; no other change.
- LEN: one cycle; next cycle wen=1, addr=2^ADDR_W-1, wdata=len zero-extended. Then go to DONE.
- len encoding: len is the index of the last data word, so N bits give len=N-1. The detector stops when its address equals len.
- DONE: wen=0, done=1. start clears done, returns to WRITE and clears the counters. Without start, DONE holds.
- Latency: 1 cycle from accepted bit to its write; the length write follows the last data write on the very next cycle.
- Overflow: stream longer than 1023 bits is forcibly terminated at index 1022. bit_ready drops, excess bits are not accepted, and the upstream must stall.
- start while in WRITE or LEN is ignored.
- bit_last is only sampled when bit_valid && bit_ready.
- Reset mid-operation returns immediately to reset values. Words already written are left in memory; there is no rollback.
- wen is never asserted for more than one address per cycle. No write ever targets address 1023 except in LEN.

Optional Feature:
- Macro: PW_EXPCNT_EN.
- Defined: a PAT_LEN-bit shift register takes each accepted bit (shift left, new bit into the LSB).
  - When it equals PATTERN, exp_cnt increments (saturating at 2^ADDR_W-1).
  - Overlapping occurrences count, matching the detector FSM.
  - Fewer than PAT_LEN bits can never match, because PATTERN's MSB is 1.
  - exp_cnt is final once done=1.
- Not defined: no shift register or counter is built, and exp_cnt is tied to 0.

Decomposition:
- Shared package pd_pkg:
  - state encodings PW_IDLE, PW_WRITE, PW_LEN, PW_DONE;
  - PD_ADDR_W=10, PD_DATA_W=10;
  - PD_LEN_ADDR=1023;
  - PD_PATTERN=8'b11001010, PD_PAT_LEN=8.
- One natural sub-module, pd_match_counter: the shift register and saturating counter, instantiated only under PW_EXPCNT_EN.
- Reuse the existing parameterised DFF for the state and wptr registers.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, then release with no start → wen=0, done=0, bit_ready=0 for 10 cycles.
- Short stream: start, then bits 1,1,0,0,1,0,1,0 with bit_last on the 8th →
  - writes addr 0..7, wdata[0] = 1,1,0,0,1,0,1,0;
  - then addr 1023, wdata=7;
  - done=1; exp_cnt=1.
- Back-pressure and gaps: bit_valid toggles every other cycle over a 20-bit stream → exactly 20 data writes at addresses 0..19 in order, and the length word equals 19.
- Overflow: 1100 bits with no bit_last → last data write at addr 1022, length word 1022, bit_ready=0 from then on, 77 bits unaccepted.
- Mid-run reset: assert rst_n=0 after 5 bits → all outputs return to reset values asynchronously. A new start writes again from addr 0.
- Overlap and restart: stream 11001010 11001010 1 (17 bits) → length word 16, exp_cnt=2. A start in DONE clears done, and the next stream begins at addr 0.
